// File: rtl/costas_loop_ctrl.sv
// costas_loop_ctrl
// Sequencer for a Costas carrier tracking loop. It runs the loop filter with
// wide acquisition coefficients, switches to the narrow tracking set once the
// phase error has stayed small for long enough, pulses the loop-filter rework
// (restart) input on every restart, and reports lock and loss-of-lock events.
//
// Build option: define COSTAS_CTRL_HYST_EN to make TRACK judge a sample bad
// only when |err| >= 2*i_lock_thresh. This gives hysteresis, so a loop that
// only just locked does not drop out on noise that sits near the threshold.
// Without it, TRACK uses the same threshold as ACQ and VERIFY.

module costas_loop_ctrl #(
  parameter int PERR_W      = 13,
  parameter int COEF_W      = 32,
  parameter int LOCK_CNT    = 64,
  parameter int UNLOCK_CNT  = 16,
  parameter int SETTLE_CNT  = 32,
  parameter int ACQ_TIMEOUT = 20000,
  parameter int REWORK_CYC  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_enable,
  input  logic [COEF_W-1:0]        i_wide_c1,
  input  logic [COEF_W-1:0]        i_wide_c2,
  input  logic [COEF_W-1:0]        i_narrow_c1,
  input  logic [COEF_W-1:0]        i_narrow_c2,
  input  logic [PERR_W-2:0]        i_lock_thresh,
  input  logic                     i_loop_valid,
  input  logic signed [PERR_W-1:0] i_phase_error,
  output logic [COEF_W-1:0]        o_pll_c1,
  output logic [COEF_W-1:0]        o_pll_c2,
  output logic                     o_rework_h,
  output logic                     o_locked,
  output logic [2:0]               o_state,
  output logic [15:0]              o_loss_cnt
);

  localparam int MAG_W = PERR_W - 1;

  // One sample/cycle counter is shared by FLUSH (clock cycles), ACQ (timeout)
  // and SETTLE (ignored samples). Only one of these is live at a time, so it
  // is sized for the largest of the three limits.
  localparam int SAMP_MAX_A = (ACQ_TIMEOUT > SETTLE_CNT) ? ACQ_TIMEOUT : SETTLE_CNT;
  localparam int SAMP_MAX   = (SAMP_MAX_A > REWORK_CYC) ? SAMP_MAX_A : REWORK_CYC;
  localparam int SAMP_W     = $clog2(SAMP_MAX + 1);
  localparam int GOOD_W     = $clog2(LOCK_CNT + 1);
  localparam int BAD_W      = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_ACQ    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_VERIFY = 3'd4,
    ST_TRACK  = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic [SAMP_W-1:0]   samp_cnt_reg, samp_cnt_next;
  logic [GOOD_W-1:0]   good_cnt_reg, good_cnt_next;
  logic [BAD_W-1:0]    bad_cnt_reg, bad_cnt_next;
  logic [COEF_W-1:0]   c1_reg, c2_reg;
  logic                rework_reg;
  logic                locked_reg;
  logic [15:0]         loss_cnt_reg;
  logic                loss_event;

  // Phase-error magnitude and per-sample quality decisions
  logic [PERR_W-1:0]   err_neg;
  logic [MAG_W-1:0]    err_mag;
  logic                sample_good;
  logic                track_bad;

  // Two's-complement magnitude. Negating the most-negative code gives that
  // code back (MSB still set), so that one case saturates to the largest
  // positive magnitude instead of wrapping to zero.
  always_comb begin
    err_neg = -i_phase_error;
    if (i_phase_error[PERR_W-1]) begin
      if (err_neg[PERR_W-1]) begin
        err_mag = {MAG_W{1'b1}};
      end else begin
        err_mag = err_neg[MAG_W-1:0];
      end
    end else begin
      err_mag = i_phase_error[MAG_W-1:0];
    end
  end

  // A threshold of zero makes every sample bad, because nothing is strictly below zero.
  assign sample_good = (err_mag < i_lock_thresh);

`ifdef COSTAS_CTRL_HYST_EN
  // 2*thresh of an MAG_W-bit value always fits in PERR_W bits, so the
  // doubled threshold can never overflow and needs no clamp.
  logic [PERR_W-1:0] thresh_x2;
  assign thresh_x2 = {i_lock_thresh, 1'b0};
  assign track_bad = ({1'b0, err_mag} >= thresh_x2);
`else
  assign track_bad = !sample_good;
`endif

  // Next-state and counter update; every state change clears all counters
  always_comb begin
    state_next    = state_reg;
    samp_cnt_next = samp_cnt_reg;
    good_cnt_next = good_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    loss_event    = 1'b0;

    if (!i_enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_FLUSH;
        end

        // Counts clock cycles, not samples. The rework pulse spans the whole state.
        ST_FLUSH: begin
          if (samp_cnt_reg == SAMP_W'(REWORK_CYC - 1)) begin
            state_next = ST_ACQ;
          end else begin
            samp_cnt_next = samp_cnt_reg + 1'b1;
          end
        end

        // Lock is tested before the timeout, so it wins when both happen on the same sample
        ST_ACQ: begin
          if (i_loop_valid) begin
            samp_cnt_next = samp_cnt_reg + 1'b1;
            if (sample_good) begin
              good_cnt_next = good_cnt_reg + 1'b1;
            end else begin
              good_cnt_next = '0;
            end
            if (sample_good && (good_cnt_reg == GOOD_W'(LOCK_CNT - 1))) begin
              state_next = ST_SETTLE;
            end else if (samp_cnt_reg == SAMP_W'(ACQ_TIMEOUT - 1)) begin
              state_next = ST_FLUSH;
            end
          end
        end

        // The loop filter is still reacting to the coefficient switch here,
        // so the error values are not judged.
        ST_SETTLE: begin
          if (i_loop_valid) begin
            if (samp_cnt_reg == SAMP_W'(SETTLE_CNT - 1)) begin
              state_next = ST_VERIFY;
            end else begin
              samp_cnt_next = samp_cnt_reg + 1'b1;
            end
          end
        end

        // The narrow loop must prove itself without a single bad sample
        ST_VERIFY: begin
          if (i_loop_valid) begin
            if (!sample_good) begin
              state_next = ST_FLUSH;
            end else if (good_cnt_reg == GOOD_W'(LOCK_CNT - 1)) begin
              state_next = ST_TRACK;
            end else begin
              good_cnt_next = good_cnt_reg + 1'b1;
            end
          end
        end

        ST_TRACK: begin
          if (i_loop_valid) begin
            if (!track_bad) begin
              bad_cnt_next = '0;
            end else if (bad_cnt_reg == BAD_W'(UNLOCK_CNT - 1)) begin
              state_next = ST_FLUSH;
              loss_event = 1'b1;
            end else begin
              bad_cnt_next = bad_cnt_reg + 1'b1;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    if (state_next != state_reg) begin
      samp_cnt_next = '0;
      good_cnt_next = '0;
      bad_cnt_next  = '0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      samp_cnt_reg <= '0;
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      samp_cnt_reg <= samp_cnt_next;
      good_cnt_reg <= good_cnt_next;
      bad_cnt_reg  <= bad_cnt_next;
    end
  end

  // These flags are computed from the next state, so they change on the same
  // edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rework_reg <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      rework_reg <= (state_next == ST_FLUSH);
      locked_reg <= (state_next == ST_TRACK);
    end
  end

  // Coefficients are captured only when FLUSH or SETTLE is entered, so
  // register writes made mid-state do not disturb a running loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_reg <= '0;
      c2_reg <= '0;
    end else if ((state_next == ST_FLUSH) && (state_reg != ST_FLUSH)) begin
      c1_reg <= i_wide_c1;
      c2_reg <= i_wide_c2;
    end else if ((state_next == ST_SETTLE) && (state_reg != ST_SETTLE)) begin
      c1_reg <= i_narrow_c1;
      c2_reg <= i_narrow_c2;
    end
  end

  // Loss-of-lock event counter. It saturates, and disabling the controller does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_reg <= '0;
    end else if (loss_event && (loss_cnt_reg != 16'hFFFF)) begin
      loss_cnt_reg <= loss_cnt_reg + 16'd1;
    end
  end

  assign o_pll_c1   = c1_reg;
  assign o_pll_c2   = c2_reg;
  assign o_rework_h = rework_reg;
  assign o_locked   = locked_reg;
  assign o_state    = state_reg;
  assign o_loss_cnt = loss_cnt_reg;

endmodule

// File: tb/tb_costas_loop_ctrl.sv
// tb_costas_loop_ctrl
// Directed checks of the Costas loop sequencer with hand-computed expectations.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at the same point.

module tb_costas_loop_ctrl;

  localparam logic [31:0] W1_C1 = 32'h1111_0001;
  localparam logic [31:0] W1_C2 = 32'h2222_0002;
  localparam logic [31:0] W2_C1 = 32'h5555_0005;
  localparam logic [31:0] W2_C2 = 32'h6666_0006;
  localparam logic [31:0] N_C1  = 32'h3333_0003;
  localparam logic [31:0] N_C2  = 32'h4444_0004;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic [31:0]        wide_c1, wide_c2, narrow_c1, narrow_c2;
  logic [11:0]        lock_thresh;
  logic               loop_valid;
  logic signed [12:0] phase_error;
  logic [31:0]        pll_c1, pll_c2;
  logic               rework_h;
  logic               locked;
  logic [2:0]         state;
  logic [15:0]        loss_cnt;

  int checks = 0;
  int errors = 0;

  costas_loop_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (enable),
    .i_wide_c1     (wide_c1),
    .i_wide_c2     (wide_c2),
    .i_narrow_c1   (narrow_c1),
    .i_narrow_c2   (narrow_c2),
    .i_lock_thresh (lock_thresh),
    .i_loop_valid  (loop_valid),
    .i_phase_error (phase_error),
    .o_pll_c1      (pll_c1),
    .o_pll_c2      (pll_c2),
    .o_rework_h    (rework_h),
    .o_locked      (locked),
    .o_state       (state),
    .o_loss_cnt    (loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid sample per call; back-to-back calls keep the strobe high on every edge
  task automatic send(input int e);
    phase_error = 13'(e);
    loop_valid  = 1'b1;
    tick();
    loop_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; loop_valid = 1'b0; phase_error = '0;
    wide_c1 = W1_C1; wide_c2 = W1_C2; narrow_c1 = N_C1; narrow_c2 = N_C2;
    lock_thresh = 12'd100;
    tick(); tick();
    checks++;
    if (state !== 3'd0 || rework_h !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl state=%0d rework=%b locked=%b want 0/0/0", state, rework_h, locked);
    end
    checks++;
    if (pll_c1 !== 32'd0 || pll_c2 !== 32'd0 || loss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_data c1=%h c2=%h loss=%0d want 0/0/0", pll_c1, pll_c2, loss_cnt);
    end
    rst_n = 1'b1;
    tick();
    $display("reset: state=%0d c1=%h loss=%0d", state, pll_c1, loss_cnt);
  endtask

  task automatic test_flush();
    int cnt;
    enable = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1 || rework_h !== 1'b1 || pll_c1 !== W1_C1 || pll_c2 !== W1_C2) begin
      errors++;
      $display("FAIL flush_entry state=%0d rework=%b c1=%h c2=%h want 1/1/%h/%h", state, rework_h, pll_c1, pll_c2, W1_C1, W1_C2);
    end
    cnt = 0;
    while (rework_h === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 8 || state !== 3'd2) begin
      errors++;
      $display("FAIL flush_len rework_cycles=%0d state=%0d want 8/2", cnt, state);
    end
    $display("flush: rework_cycles=%0d state=%0d", cnt, state);
  endtask

  task automatic test_acq_lock();
    wide_c1 = W2_C1; wide_c2 = W2_C2;
    for (int i = 0; i < 63; i++) send((i % 2) ? -50 : 50);
    checks++;
    if (state !== 3'd2 || pll_c1 !== W1_C1) begin
      errors++;
      $display("FAIL acq_63 state=%0d c1=%h want 2/%h", state, pll_c1, W1_C1);
    end
    send(-50);
    checks++;
    if (state !== 3'd3 || pll_c1 !== N_C1 || pll_c2 !== N_C2) begin
      errors++;
      $display("FAIL acq_to_settle state=%0d c1=%h c2=%h want 3/%h/%h", state, pll_c1, pll_c2, N_C1, N_C2);
    end
    for (int i = 0; i < 31; i++) send(3000);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL settle_31 state=%0d want 3", state);
    end
    send(3000);
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL settle_to_verify state=%0d want 4", state);
    end
    for (int i = 0; i < 63; i++) send((i % 2) ? 50 : -50);
    checks++;
    if (state !== 3'd4 || locked !== 1'b0) begin
      errors++;
      $display("FAIL verify_63 state=%0d locked=%b want 4/0", state, locked);
    end
    send(50);
    checks++;
    if (state !== 3'd5 || locked !== 1'b1) begin
      errors++;
      $display("FAIL verify_to_track state=%0d locked=%b want 5/1", state, locked);
    end
    $display("acq_lock: state=%0d locked=%b c1=%h", state, locked, pll_c1);
  endtask

  task automatic test_track_loss();
    // err=150 counts as bad with a single threshold and as good with hysteresis.
    // In both builds the good sample afterwards clears the run.
    for (int i = 0; i < 15; i++) send(150);
    send(50);
`ifdef COSTAS_CTRL_HYST_EN
    for (int i = 0; i < 20; i++) send(150);
`endif
    checks++;
    if (state !== 3'd5 || locked !== 1'b1) begin
      errors++;
      $display("FAIL track_hold state=%0d locked=%b want 5/1", state, locked);
    end
    for (int i = 0; i < 15; i++) send(-4096);
    checks++;
    if (state !== 3'd5 || locked !== 1'b1 || loss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL track_15bad state=%0d locked=%b loss=%0d want 5/1/0", state, locked, loss_cnt);
    end
    send(-4096);
    checks++;
    if (state !== 3'd1 || locked !== 1'b0 || loss_cnt !== 16'd1 || rework_h !== 1'b1) begin
      errors++;
      $display("FAIL track_loss state=%0d locked=%b loss=%0d rework=%b want 1/0/1/1", state, locked, loss_cnt, rework_h);
    end
    checks++;
    if (pll_c1 !== W2_C1 || pll_c2 !== W2_C2) begin
      errors++;
      $display("FAIL loss_coef c1=%h c2=%h want %h/%h", pll_c1, pll_c2, W2_C1, W2_C2);
    end
    $display("track_loss: state=%0d loss=%0d c1=%h", state, loss_cnt, pll_c1);
  endtask

  task automatic test_good_reset();
    // Samples that arrive during FLUSH are ignored
    for (int i = 0; i < 8; i++) send(50);
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL reflush_done state=%0d want 2", state);
    end
    for (int i = 0; i < 63; i++) send((i % 2) ? -99 : 99);
    send(200);
    for (int i = 0; i < 63; i++) send((i % 2) ? 99 : -99);
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL good_cnt_cleared state=%0d want 2", state);
    end
    send(99);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL second_run_lock state=%0d want 3", state);
    end
    for (int i = 0; i < 32; i++) send(0);
    for (int i = 0; i < 10; i++) send(20);
    send(100);
    checks++;
    if (state !== 3'd1 || rework_h !== 1'b1 || pll_c1 !== W2_C1) begin
      errors++;
      $display("FAIL verify_bad state=%0d rework=%b c1=%h want 1/1/%h", state, rework_h, pll_c1, W2_C1);
    end
    $display("good_reset: state=%0d", state);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 8; i++) tick();
    lock_thresh = 12'd0;
    for (int i = 0; i < 19999; i++) send(0);
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL timeout_19999 state=%0d want 2", state);
    end
    send(0);
    checks++;
    if (state !== 3'd1 || rework_h !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flush state=%0d rework=%b want 1/1", state, rework_h);
    end
    $display("timeout: state=%0d", state);
  endtask

  task automatic test_disable();
    int cnt;
    tick(); tick(); tick();
    enable = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || rework_h !== 1'b0 || locked !== 1'b0 || loss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL disable state=%0d rework=%b locked=%b loss=%0d want 0/0/0/1", state, rework_h, locked, loss_cnt);
    end
    enable = 1'b1;
    tick();
    cnt = 0;
    while (rework_h === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 8 || state !== 3'd2) begin
      errors++;
      $display("FAIL reenable_flush rework_cycles=%0d state=%0d want 8/2", cnt, state);
    end
    $display("disable: rework_cycles=%0d state=%0d", cnt, state);
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || pll_c1 !== 32'd0 || loss_cnt !== 16'd0 || rework_h !== 1'b0) begin
      errors++;
      $display("FAIL async_reset state=%0d c1=%h loss=%0d rework=%b want 0/0/0/0", state, pll_c1, loss_cnt, rework_h);
    end
    $display("async_reset: state=%0d loss=%0d", state, loss_cnt);
  endtask

  initial begin
    test_reset();
    test_flush();
    test_acq_lock();
    test_track_loss();
    test_good_reset();
    test_timeout();
    test_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
